// File: rtl/idma_reg64_launcher.sv
// idma_reg64_launcher
//
// Register-bus initiator that drives the 64-bit iDMA register frontend from
// a simple job stream. Each accepted job writes SRC, DST, NUM_BYTES and CONF,
// reads NEXT_ID to launch the transfer and learn its ID, waits for
// completion, clears IPSR and then returns one response beat.
//
// Optional feature macro: IDMA_LAUNCHER_IRQ_EN
//   defined   : completion is taken from irq_i[1]; WAIT issues no bus traffic.
//   undefined : completion is found by polling DONE every PollGap idle cycles.
//
// Parameters
//   AddrWidth : width of the job source, destination and length fields
//   PollGap   : idle cycles between DONE polls (>= 1)
//   RegBase   : byte offset of the DMA register window on the reg bus
//
// Ports
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   job_valid_i/job_ready_o : job handshake
//   job_src_i/dst_i/len_i   : job fields; job_decouple_i goes to CONF[0]
//   rsp_valid_o/rsp_ready_i : completion handshake
//   rsp_id_o, rsp_err_o     : transfer ID, job failed
//   reg_valid_o ... reg_wstrb_o : reg-bus request (registered)
//   reg_ready_i, reg_rdata_i, reg_error_i : reg-bus response
//   irq_i                   : frontend interrupts, [0] read done, [1] write done
//   busy_o                  : state machine is not IDLE
module idma_reg64_launcher #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned PollGap   = 4,
  parameter logic [5:0]  RegBase   = 6'h00
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  input  logic [AddrWidth-1:0] job_src_i,
  input  logic [AddrWidth-1:0] job_dst_i,
  input  logic [AddrWidth-1:0] job_len_i,
  input  logic                 job_decouple_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [63:0]          rsp_id_o,
  output logic                 rsp_err_o,
  output logic                 reg_valid_o,
  output logic                 reg_write_o,
  output logic [5:0]           reg_addr_o,
  output logic [63:0]          reg_wdata_o,
  output logic [7:0]           reg_wstrb_o,
  input  logic                 reg_ready_i,
  input  logic [63:0]          reg_rdata_i,
  input  logic                 reg_error_i,
  input  logic [1:0]           irq_i,
  output logic                 busy_o
);

  localparam logic [5:0] OFF_SRC     = 6'h00;
  localparam logic [5:0] OFF_DST     = 6'h08;
  localparam logic [5:0] OFF_LEN     = 6'h10;
  localparam logic [5:0] OFF_CONF    = 6'h18;
  localparam logic [5:0] OFF_NEXT_ID = 6'h28;
  localparam logic [5:0] OFF_DONE    = 6'h30;
  localparam logic [5:0] OFF_IPSR    = 6'h38;

  typedef enum logic [3:0] {
    IDLE, WR_SRC, WR_DST, WR_LEN, WR_CONF, LAUNCH, WAIT, CLR, RESP
  } state_e;

  state_e state_q, state_d;

  logic [AddrWidth-1:0] src_q, dst_q, len_q;
  logic                 decouple_q;
  logic [63:0]          id_q;
  logic                 err_q;

  logic        job_fire;
  logic        xfer;
  logic        issue;
  logic        req_write;
  logic [5:0]  req_off;
  logic [63:0] req_wdata;

  assign reg_wstrb_o = 8'hFF;
  assign rsp_id_o    = id_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = (state_q != IDLE);
  assign job_fire    = job_valid_i & job_ready_o;
  assign xfer        = reg_valid_o & reg_ready_i;

`ifdef IDMA_LAUNCHER_IRQ_EN
  // Read-done interrupt carries no information for a completed transfer.
  logic unused_irq_rd;
  assign unused_irq_rd = irq_i[0];
`else
  logic [15:0] gap_q;
  logic        unused_irq;
  assign unused_irq = ^irq_i;
`endif

  // Next state and the request each access state would issue.
  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    req_write   = 1'b1;
    req_off     = OFF_SRC;
    req_wdata   = '0;
    job_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted so the reset value is 0.
        job_ready_o = ~rst_i;
        if (job_valid_i && !rst_i) begin
          state_d = (job_len_i == '0) ? RESP : WR_SRC;
        end
      end
      WR_SRC: begin
        issue     = ~reg_valid_o;
        req_wdata = 64'(src_q);
        if (xfer) state_d = WR_DST;
      end
      WR_DST: begin
        issue     = ~reg_valid_o;
        req_off   = OFF_DST;
        req_wdata = 64'(dst_q);
        if (xfer) state_d = WR_LEN;
      end
      WR_LEN: begin
        issue     = ~reg_valid_o;
        req_off   = OFF_LEN;
        req_wdata = 64'(len_q);
        if (xfer) state_d = WR_CONF;
      end
      WR_CONF: begin
        issue     = ~reg_valid_o;
        req_off   = OFF_CONF;
        req_wdata = {63'b0, decouple_q};
        if (xfer) state_d = LAUNCH;
      end
      LAUNCH: begin
        issue     = ~reg_valid_o;
        req_write = 1'b0;
        req_off   = OFF_NEXT_ID;
        if (xfer) state_d = WAIT;
      end
      WAIT: begin
`ifdef IDMA_LAUNCHER_IRQ_EN
        if (irq_i[1]) state_d = CLR;
`else
        issue     = ~reg_valid_o && (gap_q == '0);
        req_write = 1'b0;
        req_off   = OFF_DONE;
        // Unsigned compare: DONE at or past our ID means our job retired.
        if (xfer && (reg_rdata_i >= id_q)) state_d = CLR;
`endif
      end
      CLR: begin
        issue     = ~reg_valid_o;
        req_off   = OFF_IPSR;
        req_wdata = 64'h3;
        if (xfer) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Any failed access ends the job; nothing further goes on the bus.
    if (xfer && reg_error_i) state_d = RESP;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Job capture, registered bus request, ID and error tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      decouple_q  <= 1'b0;
      id_q        <= '0;
      err_q       <= 1'b0;
      reg_valid_o <= 1'b0;
      reg_write_o <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
    end else begin
      if (job_fire) begin
        src_q      <= job_src_i;
        dst_q      <= job_dst_i;
        len_q      <= job_len_i;
        decouple_q <= job_decouple_i;
        id_q       <= '0;
        err_q      <= (job_len_i == '0);
      end
      // A state is entered with reg_valid_o low, so the request goes out one
      // cycle later, leaving exactly one idle bus cycle between accesses.
      if (issue) begin
        reg_valid_o <= 1'b1;
        reg_write_o <= req_write;
        reg_addr_o  <= RegBase + req_off;
        reg_wdata_o <= req_wdata;
      end else if (xfer) begin
        reg_valid_o <= 1'b0;
      end
      if (xfer) begin
        if (reg_error_i) begin
          err_q <= 1'b1;
        end else if (state_q == LAUNCH) begin
          id_q <= reg_rdata_i;
        end
      end
    end
  end

`ifndef IDMA_LAUNCHER_IRQ_EN
  // Loaded with PollGap-1 on a DONE completion; together with the cycle in
  // which reg_valid_o drops this gives PollGap idle cycles between polls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gap_q <= '0;
    end else if ((state_q == WAIT) && xfer) begin
      gap_q <= 16'(PollGap - 1);
    end else if (gap_q != '0) begin
      gap_q <= gap_q - 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idma_reg64_launcher.sv
module tb_idma_reg64_launcher;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        job_valid_i = 1'b0;
  logic        job_ready_o;
  logic [63:0] job_src_i = '0, job_dst_i = '0, job_len_i = '0;
  logic        job_decouple_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [63:0] rsp_id_o;
  logic        rsp_err_o;
  logic        reg_valid_o, reg_write_o;
  logic [5:0]  reg_addr_o;
  logic [63:0] reg_wdata_o;
  logic [7:0]  reg_wstrb_o;
  logic        reg_ready_i, reg_error_i;
  logic [63:0] reg_rdata_i;
  logic [1:0]  irq_i;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  idma_reg64_launcher dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_src_i(job_src_i), .job_dst_i(job_dst_i), .job_len_i(job_len_i),
    .job_decouple_i(job_decouple_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o),
    .reg_valid_o(reg_valid_o), .reg_write_o(reg_write_o),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
    .reg_ready_i(reg_ready_i), .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i),
    .irq_i(irq_i), .busy_o(busy_o)
  );

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [63:0] wdata;
  } acc_t;

  typedef struct packed {
    logic [63:0] id;
    logic        err;
  } rsp_t;

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];

  int n_vec = 0;
  int n_err = 0;

  // Bus-model configuration for the job currently being run.
  logic [63:0] cfg_nid = 64'd5;
  logic [63:0] cfg_done_lo = 64'd4;
  logic [63:0] cfg_done_hi = 64'd5;
  int          cfg_polls = 3;
  int          cfg_err_idx = -1;
  int          cfg_rdly = 0;
  logic [1:0]  cfg_irq = 2'b10;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected bus accesses and response for one job.
  task automatic push_expect(input logic [63:0] src, input logic [63:0] dst,
                             input logic [63:0] len, input logic dec);
    acc_t seq[$];
    rsp_t r;
    if (len == 64'd0) begin
      r.id  = 64'd0;
      r.err = 1'b1;
      exp_rsp.push_back(r);
      return;
    end
    seq.push_back(acc_t'{1'b1, 6'h00, src});
    seq.push_back(acc_t'{1'b1, 6'h08, dst});
    seq.push_back(acc_t'{1'b1, 6'h10, len});
    seq.push_back(acc_t'{1'b1, 6'h18, {63'b0, dec}});
    seq.push_back(acc_t'{1'b0, 6'h28, 64'd0});
`ifndef IDMA_LAUNCHER_IRQ_EN
    for (int i = 0; i < cfg_polls; i++) seq.push_back(acc_t'{1'b0, 6'h30, 64'd0});
`endif
    seq.push_back(acc_t'{1'b1, 6'h38, 64'h3});
    r.id  = cfg_nid;
    r.err = 1'b0;
    if (cfg_err_idx >= 0 && cfg_err_idx < seq.size()) begin
      while (seq.size() > cfg_err_idx + 1) void'(seq.pop_back());
      r.err = 1'b1;
      r.id  = (cfg_err_idx >= 5) ? cfg_nid : 64'd0;
    end
    foreach (seq[i]) exp_acc.push_back(seq[i]);
    exp_rsp.push_back(r);
  endtask

  task automatic send_job(input logic [63:0] src, input logic [63:0] dst,
                          input logic [63:0] len, input logic dec);
    int t;
    t = 0;
    @(negedge clk_i);
    job_src_i      = src;
    job_dst_i      = dst;
    job_len_i      = len;
    job_decouple_i = dec;
    job_valid_i    = 1'b1;
    while (!job_ready_o && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    chk("job_ready", job_ready_o, 1);
    @(posedge clk_i);
    #1 job_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, input int exp_lat);
    int   t;
    rsp_t e;
    t = 0;
    @(negedge clk_i);
    while (!rsp_valid_o && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    chk("rsp_valid", rsp_valid_o, 1);
    if (!rsp_valid_o) return;
    if (exp_lat >= 0) chk("rsp_latency", t, exp_lat);
    chk("rsp_pending", 64'(exp_rsp.size() != 0), 64'd1);
    if (exp_rsp.size() == 0) return;
    e = exp_rsp.pop_front();
    chk("rsp_id", rsp_id_o, e.id);
    chk("rsp_err", rsp_err_o, e.err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      chk("bp_rsp_valid", rsp_valid_o, 1);
      chk("bp_rsp_id", rsp_id_o, e.id);
      chk("bp_rsp_err", rsp_err_o, e.err);
      chk("bp_job_ready", job_ready_o, 0);
      chk("bp_reg_valid", reg_valid_o, 0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("rsp_taken", rsp_valid_o, 0);
    chk("idle_ready", job_ready_o, 1);
    chk("acc_left", 64'(exp_acc.size()), 64'd0);
  endtask

  task automatic run_job(input logic [63:0] src, input logic [63:0] dst,
                         input logic [63:0] len, input logic dec,
                         input int hold, input int exp_lat);
    push_expect(src, dst, len, dec);
    send_job(src, dst, len, dec);
    wait_rsp(hold, exp_lat);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_job_ready"}, job_ready_o, 0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_rsp_id"}, rsp_id_o, 0);
    chk({tag, "_rsp_err"}, rsp_err_o, 0);
    chk({tag, "_reg_valid"}, reg_valid_o, 0);
    chk({tag, "_reg_write"}, reg_write_o, 0);
    chk({tag, "_reg_addr"}, reg_addr_o, 0);
    chk({tag, "_reg_wdata"}, reg_wdata_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  // Reg-bus responder: checks each request against the expected queue and
  // holds it stable while ready is withheld.
  initial begin
    int   wcnt, acc_idx, poll_n, irq_cd;
    logic busy_q, have_cur;
    acc_t cur;
    wcnt = 0; acc_idx = 0; poll_n = 0; irq_cd = 0;
    busy_q = 1'b0; have_cur = 1'b0; cur = '0;
    reg_ready_i = 1'b0; reg_error_i = 1'b0; reg_rdata_i = '0; irq_i = '0;
    forever begin
      @(negedge clk_i);
      reg_ready_i = 1'b0;
      reg_error_i = 1'b0;
      irq_i       = 2'b00;
      if (rst_i) begin
        wcnt = 0; irq_cd = 0; busy_q = 1'b0; have_cur = 1'b0;
      end else begin
        if (busy_o && !busy_q) begin
          acc_idx = 0;
          poll_n  = 0;
        end
        busy_q = busy_o;
        if (irq_cd > 0) begin
          irq_cd--;
          if (irq_cd == 0) irq_i = cfg_irq;
        end
        if (reg_valid_o) begin
          if (wcnt == 0) begin
            chk("acc_expected", 64'(exp_acc.size() != 0), 64'd1);
            have_cur = (exp_acc.size() != 0);
            if (have_cur) cur = exp_acc.pop_front();
          end
          if (have_cur) begin
            chk("req_write", reg_write_o, cur.wr);
            chk("req_addr", reg_addr_o, cur.addr);
            if (cur.wr) begin
              chk("req_wdata", reg_wdata_o, cur.wdata);
              chk("req_wstrb", reg_wstrb_o, 8'hFF);
            end
          end
          if (wcnt >= cfg_rdly) begin
            reg_ready_i = 1'b1;
            reg_error_i = (acc_idx == cfg_err_idx);
            if (reg_addr_o == 6'h28) begin
              reg_rdata_i = cfg_nid;
              if (!reg_error_i) irq_cd = 20;
            end else if (reg_addr_o == 6'h30) begin
              poll_n++;
              reg_rdata_i = (poll_n >= cfg_polls) ? cfg_done_hi : cfg_done_lo;
            end else begin
              reg_rdata_i = 64'hDEAD_BEEF_0000_0000;
            end
            acc_idx++;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  initial begin
    int t;
`ifdef IDMA_LAUNCHER_IRQ_EN
    cfg_irq = 2'b10;
`else
    cfg_irq = 2'b11;
`endif
    #1;
    chk_reset_outputs("rst");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", job_ready_o, 1);
    chk("post_rst_busy", busy_o, 0);

    // Basic job, zero-wait bus, DONE reaches the ID on the third poll.
    cfg_nid = 64'd5; cfg_done_lo = 64'd4; cfg_done_hi = 64'd5; cfg_polls = 3;
    cfg_err_idx = -1; cfg_rdly = 0;
    run_job(64'h1000, 64'h2000, 64'h40, 1'b0, 0, -1);

    // Zero length: response the cycle after acceptance, no bus traffic.
    run_job(64'h3000, 64'h4000, 64'h0, 1'b0, 0, 0);

    // Error on the DST write.
    cfg_err_idx = 1;
    run_job(64'h5000, 64'h6000, 64'h80, 1'b0, 0, -1);

    // Backpressure on the bus and on the response.
    cfg_err_idx = -1; cfg_rdly = 3; cfg_nid = 64'd9; cfg_done_lo = 64'd8;
    cfg_done_hi = 64'd9; cfg_polls = 2;
    run_job(64'h7000, 64'h8000, 64'h100, 1'b0, 10, -1);

    // Wide ID: DONE below ID only under unsigned compare; DONE ends past ID.
    cfg_rdly = 1; cfg_nid = 64'h8000_0000_0000_0000;
    cfg_done_lo = 64'h7FFF_FFFF_FFFF_FFFF; cfg_done_hi = 64'h8000_0000_0000_0005;
    cfg_polls = 2;
    run_job(64'hFFFF_0000_1234_5678, 64'hABCD_0000_0000_0010, 64'h1_0000_0000, 1'b1, 0, -1);

    // Error on the NEXT_ID read: no ID was captured.
    cfg_rdly = 0; cfg_nid = 64'd33; cfg_done_lo = 64'd32; cfg_done_hi = 64'd33;
    cfg_polls = 1; cfg_err_idx = 4;
    run_job(64'h10, 64'h20, 64'h30, 1'b1, 0, -1);

    // Error after the launch: the captured ID is reported.
    cfg_err_idx = 5;
    run_job(64'h40, 64'h50, 64'h60, 1'b0, 0, -1);

    // Reset while the NUM_BYTES write is pending.
    cfg_err_idx = -1; cfg_rdly = 5; cfg_nid = 64'd12; cfg_done_lo = 64'd11;
    cfg_done_hi = 64'd12; cfg_polls = 1;
    push_expect(64'hA000, 64'hB000, 64'h200, 1'b0);
    send_job(64'hA000, 64'hB000, 64'h200, 1'b0);
    t = 0;
    while (!(reg_valid_o && reg_addr_o == 6'h10) && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    chk("rst_at_len", {58'b0, reg_addr_o}, 64'h10);
    #2 rst_i = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    exp_acc.delete();
    exp_rsp.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("midrst_ready", job_ready_o, 1);
    cfg_rdly = 0;
    run_job(64'hC000, 64'hD000, 64'h300, 1'b1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
